// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: arbiter state encoding and Wishbone cycle-type constants
package wb_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_OWN0 = 2'b01, ST_OWN1 = 2'b10} arb_state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts unterminated strobe cycles and flags expiry at TIMEOUT
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic run,
  input  logic clear,
  output logic expire
);
  logic [TW-1:0] cnt;
  always_ff @(posedge wb_clk)
    if (wb_rst || clear || TIMEOUT == 0) cnt <= '0;
    else if (run) cnt <= cnt + TW'(1);
  assign expire = (TIMEOUT != 0) && run && cnt == TW'(TIMEOUT - 1);
endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: round-robin two-master Wishbone arbiter with cycle-locked grant and hang watchdog
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);
  arb_state_t state;
  logic last_owner, own, sel, cyc_x, stb_x, term, run, expire, fwd;
  assign own = state != ST_IDLE && !wb_rst;
  assign sel = state == ST_OWN1;
  assign cyc_x = sel ? m1_cyc_i : m0_cyc_i;
  assign stb_x = sel ? m1_stb_i : m0_stb_i;
  assign term = s_ack_i || s_err_i || s_rty_i;
  assign run = own && cyc_x && stb_x && !term;
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wd (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .run    (run),
    .clear  (!own || !cyc_x || term || expire),
    .expire (expire)
  );
  assign s_adr_o = sel ? m1_adr_i : m0_adr_i;
  assign s_dat_o = sel ? m1_dat_i : m0_dat_i;
  assign s_sel_o = sel ? m1_sel_i : m0_sel_i;
  assign s_cti_o = sel ? m1_cti_i : m0_cti_i;
  assign s_bte_o = sel ? m1_bte_i : m0_bte_i;
  assign s_we_o = own && (sel ? m1_we_i : m0_we_i);
  // an expiring access is pulled off the bus in the same cycle its master sees ERR
  assign s_cyc_o = own && cyc_x && !expire;
  assign s_stb_o = s_cyc_o && stb_x;
  assign fwd = own && cyc_x;
  assign m0_ack_o = fwd && !sel && s_ack_i;
  assign m0_err_o = fwd && !sel && (s_err_i || expire);
  assign m0_rty_o = fwd && !sel && s_rty_i;
  assign m1_ack_o = fwd && sel && s_ack_i;
  assign m1_err_o = fwd && sel && (s_err_i || expire);
  assign m1_rty_o = fwd && sel && s_rty_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o = {2{own}} & state;
  assign timeout_o = expire;
  always_ff @(posedge wb_clk)
    if (wb_rst) begin
      state <= ST_IDLE;
      last_owner <= 1'b1;
    end else case (state)
      ST_IDLE:
        if (m0_cyc_i && (!m1_cyc_i || last_owner)) state <= ST_OWN0;
        else if (m1_cyc_i) state <= ST_OWN1;
      default:
        if (expire || !cyc_x) begin
          last_owner <= sel;
          state <= expire ? ST_IDLE : (sel ? m0_cyc_i : m1_cyc_i) ? (sel ? ST_OWN0 : ST_OWN1) : ST_IDLE;
        end
    endcase
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter: scenario tasks plus a randomized two-master run against a memory model
module tb_wb_ram_arbiter;
  import wb_arb_pkg::*;
  localparam int TO = 8;
  logic wb_clk = 1'b0;
  logic wb_rst;
  always #5 wb_clk = ~wb_clk;
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0] msel [2];
  logic mwe [2];
  logic mcyc [2];
  logic mstb [2];
  logic [2:0] mcti [2];
  logic [1:0] mbte [2];
  wire [31:0] mdo [2];
  wire [1:0] mack, merr, mrty;
  wire [31:0] s_adr_o, s_dat_o;
  wire [3:0] s_sel_o;
  wire s_we_o, s_cyc_o, s_stb_o, timeout_o;
  wire [2:0] s_cti_o;
  wire [1:0] s_bte_o, grant_o;
  logic [31:0] s_dat_i;
  logic s_ack_i, s_err_i, s_rty_i;
  int total = 0;
  int bad = 0;

  wb_ram_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO), .TW(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_sel_i(msel[0]), .m0_we_i(mwe[0]),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_cti_i(mcti[0]), .m0_bte_i(mbte[0]),
    .m0_dat_o(mdo[0]), .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rty_o(mrty[0]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_sel_i(msel[1]), .m1_we_i(mwe[1]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_cti_i(mcti[1]), .m1_bte_i(mbte[1]),
    .m1_dat_o(mdo[1]), .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rty_o(mrty[1]),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      madr[n] = '0; mdat[n] = '0; msel[n] = 4'hF; mwe[n] = 1'b0;
      mcyc[n] = 1'b0; mstb[n] = 1'b0; mcti[n] = CTI_CLASSIC; mbte[n] = 2'b00;
    end
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    clear_inputs();
    step();
    step();
    wb_rst = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    clear_inputs();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
    step();
    step();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rst_grant: got %b want 00", grant_o); end
    total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0) begin bad++; $display("FAIL rst_slave_ctl: cyc=%b stb=%b we=%b want 0", s_cyc_o, s_stb_o, s_we_o); end
    total++; if (mack !== 2'b00 || merr !== 2'b00 || mrty !== 2'b00) begin bad++; $display("FAIL rst_term: ack=%b err=%b rty=%b want 00", mack, merr, mrty); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
    wb_rst = 1'b0;
    clear_inputs();
    step();
    total++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin bad++; $display("FAIL post_rst_idle: grant=%b cyc=%b want 00/0", grant_o, s_cyc_o); end
  endtask

  task automatic test_single_read();
    step();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h0000_0100;
    #1;
    total++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin bad++; $display("FAIL rd_latency: cyc=%b grant=%b want 0/00", s_cyc_o, grant_o); end
    step();
    total++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b0) begin bad++; $display("FAIL rd_slave_ctl: cyc=%b stb=%b we=%b want 1/1/0", s_cyc_o, s_stb_o, s_we_o); end
    total++; if (s_adr_o !== 32'h0000_0100) begin bad++; $display("FAIL rd_adr: got %h want 00000100", s_adr_o); end
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rd_grant: got %b want 01", grant_o); end
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    #1;
    total++; if (mack !== 2'b01) begin bad++; $display("FAIL rd_ack: got %b want 01", mack); end
    total++; if (mdo[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", mdo[0]); end
    step();
    s_ack_i = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
    #1;
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL rd_release_cyc: got %b want 0", s_cyc_o); end
    step();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rd_idle: got %b want 00", grant_o); end
  endtask

  task automatic test_tie();
    logic [31:0] r;
    do_reset();
    for (int n = 0; n < 2; n++) begin mcyc[n] = 1'b1; mstb[n] = 1'b1; madr[n] = $urandom; end
    #1;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tie_latency: got %b want 00", grant_o); end
    step();
    total++; if (grant_o !== 2'b01 || s_adr_o !== madr[0]) begin bad++; $display("FAIL tie_first: grant=%b adr=%h want 01/%h", grant_o, s_adr_o, madr[0]); end
    s_rty_i = 1'b1;
    #1;
    total++; if (mrty !== 2'b01 || mack !== 2'b00) begin bad++; $display("FAIL tie_rty: rty=%b ack=%b want 01/00", mrty, mack); end
    step();
    s_rty_i = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
    #1;
    total++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin bad++; $display("FAIL tie_release: cyc=%b grant=%b want 0/01", s_cyc_o, grant_o); end
    step();
    total++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b1 || s_adr_o !== madr[1]) begin bad++; $display("FAIL tie_handover: grant=%b cyc=%b adr=%h want 10/1/%h", grant_o, s_cyc_o, s_adr_o, madr[1]); end
    r = $urandom;
    s_ack_i = 1'b1; s_dat_i = r;
    #1;
    total++; if (mack !== 2'b10 || mdo[1] !== r) begin bad++; $display("FAIL tie_m1_ack: ack=%b dat=%h want 10/%h", mack, mdo[1], r); end
    step();
    s_ack_i = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    step();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tie_idle: got %b want 00", grant_o); end
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mcyc[1] = 1'b1; mstb[1] = 1'b1;
    step();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL tie_second: got %b want 01", grant_o); end
    for (int n = 0; n < 2; n++) begin mcyc[n] = 1'b0; mstb[n] = 1'b0; end
    step();
    step();
  endtask

  task automatic test_burst();
    logic [31:0] base;
    base = $urandom & 32'hFFFF_FFF0;
    step();
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = base; mcti[1] = CTI_INCR; msel[1] = 4'($urandom);
    step();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = $urandom;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        mstb[1] = 1'b0;
        #1;
        total++; if (grant_o !== 2'b10 || s_stb_o !== 1'b0) begin bad++; $display("FAIL burst_gap: grant=%b stb=%b want 10/0", grant_o, s_stb_o); end
        step();
        mstb[1] = 1'b1;
      end
      madr[1] = base + 32'(4 * b); mdat[1] = $urandom; mcti[1] = b == 3 ? CTI_EOB : CTI_INCR;
      s_ack_i = 1'b1; s_dat_i = $urandom;
      #1;
      total++; if (grant_o !== 2'b10 || mack !== 2'b10) begin bad++; $display("FAIL burst_beat%0d: grant=%b ack=%b want 10/10", b, grant_o, mack); end
      total++; if (s_cti_o !== mcti[1] || s_adr_o !== madr[1] || s_dat_o !== mdat[1] || s_sel_o !== msel[1] || s_we_o !== 1'b1) begin bad++; $display("FAIL burst_fwd%0d: cti=%b adr=%h dat=%h sel=%h we=%b want %b/%h/%h/%h/1", b, s_cti_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, mcti[1], madr[1], mdat[1], msel[1]); end
      step();
      s_ack_i = 1'b0;
    end
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    #1;
    total++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b10) begin bad++; $display("FAIL burst_release: cyc=%b grant=%b want 0/10", s_cyc_o, grant_o); end
    step();
    total++; if (grant_o !== 2'b01 || s_adr_o !== madr[0] || s_we_o !== 1'b0) begin bad++; $display("FAIL burst_switch: grant=%b adr=%h we=%b want 01/%h/0", grant_o, s_adr_o, s_we_o, madr[0]); end
    s_err_i = 1'b1;
    #1;
    total++; if (merr !== 2'b01 || mack !== 2'b00) begin bad++; $display("FAIL burst_err: err=%b ack=%b want 01/00", merr, mack); end
    step();
    s_err_i = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0;
    step();
  endtask

  task automatic test_timeout(input bit ack_last);
    step();
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = $urandom; mdat[1] = $urandom; mcti[1] = CTI_CLASSIC;
    #1;
    total++; if (s_stb_o !== 1'b0) begin bad++; $display("FAIL wd_latency: stb=%b want 0", s_stb_o); end
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k == TO) s_ack_i = ack_last;
      #1;
      if (k < TO) begin
        total++; if (s_stb_o !== 1'b1 || merr !== 2'b00 || timeout_o !== 1'b0) begin bad++; $display("FAIL wd_wait%0d: stb=%b err=%b to=%b want 1/00/0", k, s_stb_o, merr, timeout_o); end
      end else if (ack_last) begin
        total++; if (mack !== 2'b10 || merr !== 2'b00 || timeout_o !== 1'b0 || s_cyc_o !== 1'b1) begin bad++; $display("FAIL wd_ack_wins: ack=%b err=%b to=%b cyc=%b want 10/00/0/1", mack, merr, timeout_o, s_cyc_o); end
      end else begin
        total++; if (merr !== 2'b10 || timeout_o !== 1'b1) begin bad++; $display("FAIL wd_fire: err=%b to=%b want 10/1", merr, timeout_o); end
        total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || mack !== 2'b00) begin bad++; $display("FAIL wd_fire_bus: cyc=%b stb=%b ack=%b want 0/0/00", s_cyc_o, s_stb_o, mack); end
      end
    end
    step();
    s_ack_i = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
    #1;
    total++; if (timeout_o !== 1'b0 || merr !== 2'b00) begin bad++; $display("FAIL wd_after: to=%b err=%b want 0/00", timeout_o, merr); end
    if (!ack_last) begin
      total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL wd_idle: grant=%b want 00", grant_o); end
    end
    step();
  endtask

  task automatic test_reset_mid();
    step();
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = $urandom;
    step();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL mid_own: grant=%b want 01", grant_o); end
    wb_rst = 1'b1;
    #1;
    total++; if (s_cyc_o !== 1'b0 || mack !== 2'b00) begin bad++; $display("FAIL mid_in_rst: cyc=%b ack=%b want 0/00", s_cyc_o, mack); end
    step();
    wb_rst = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0; s_ack_i = 1'b1; s_dat_i = $urandom;
    #1;
    total++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || mack !== 2'b00) begin bad++; $display("FAIL mid_after: cyc=%b grant=%b ack=%b want 0/00/00", s_cyc_o, grant_o, mack); end
    step();
    s_ack_i = 1'b0;
    for (int n = 0; n < 2; n++) begin mcyc[n] = 1'b1; mstb[n] = 1'b1; end
    step();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL mid_tie: grant=%b want 01", grant_o); end
    for (int n = 0; n < 2; n++) begin mcyc[n] = 1'b0; mstb[n] = 1'b0; end
    step();
    step();
  endtask

  // Both masters stream single accesses; while both have work the grants must alternate,
  // reads must see the memory image implied by earlier completed writes.
  task automatic test_random();
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int rem [2];
    bit rel [2];
    int wait_c, last, want, cycles, diff;
    do_reset();
    for (int i = 0; i < 16; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    rem[0] = 12; rem[1] = 12; rel[0] = 0; rel[1] = 0;
    wait_c = -1; last = 1; cycles = 0;
    while ((rem[0] > 0 || rem[1] > 0 || mcyc[0] || mcyc[1]) && cycles < 600) begin
      for (int n = 0; n < 2; n++)
        if (rel[n]) begin
          mcyc[n] = 1'b0; mstb[n] = 1'b0; rel[n] = 0;
        end else if (!mcyc[n] && rem[n] > 0) begin
          mcyc[n] = 1'b1; mstb[n] = 1'b1; mwe[n] = 1'($urandom_range(0, 1));
          madr[n] = 32'($urandom_range(0, 15)) << 2; mdat[n] = $urandom;
        end
      s_ack_i = 1'b0;
      #1;
      if (s_stb_o) begin
        if (wait_c < 0) wait_c = $urandom_range(0, 3);
        if (wait_c == 0) begin
          s_ack_i = 1'b1;
          s_dat_i = mem[s_adr_o[5:2]];
          if (s_we_o) mem[s_adr_o[5:2]] = s_dat_o;
          wait_c = -1;
        end else wait_c--;
      end
      #1;
      if (s_ack_i) begin
        want = (rem[0] > 0 && (last == 1 || rem[1] == 0)) ? 0 : 1;
        total++; if (mack !== (want == 1 ? 2'b10 : 2'b01) || s_adr_o !== madr[want]) begin bad++; $display("FAIL rnd_owner: ack=%b adr=%h want m%0d adr %h", mack, s_adr_o, want, madr[want]); end
        if (!mwe[want]) begin
          total++; if (mdo[want] !== ref_mem[madr[want][5:2]]) begin bad++; $display("FAIL rnd_read: got %h want %h", mdo[want], ref_mem[madr[want][5:2]]); end
        end else ref_mem[madr[want][5:2]] = mdat[want];
        rem[want]--; rel[want] = 1; last = want;
      end
      cycles++;
      step();
    end
    total++; if (cycles >= 600) begin bad++; $display("FAIL rnd_budget: cycles=%0d want <600, rem=%0d/%0d", cycles, rem[0], rem[1]); end
    diff = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) diff++;
    total++; if (diff != 0) begin bad++; $display("FAIL rnd_mem: %0d words differ, want 0", diff); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master, one-slave Wishbone B4 arbiter that shares the RAM slave port between the CPU instruction bus (master 0) and data bus (master 1).
- Sits between the interconnect ram0 slave port and wb_ram, or directly between the two CPU buses and a dedicated RAM.
- Arbitration is round-robin with grant locked for the whole cycle (CYC high, including bursts).
- A watchdog terminates hung slave accesses with ERR.

Parameters:
- AW, 32, address width
- DW, 32, data width; SEL width is DW/8
- TIMEOUT, 255, cycles of STB without ACK/ERR/RTY before forced ERR; 0 disables the watchdog
- TW, 8, watchdog counter width; TIMEOUT must be < 2**TW

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous reset, active-high
- mN_adr_i  in  AW  master N address (N=0,1; each mN_ line below is one port per master)
- mN_dat_i  in  DW  master N write data
- mN_sel_i  in  DW/8  master N byte select
- mN_we_i / mN_cyc_i / mN_stb_i  in  1 each  master N control
- mN_cti_i  in  3 ; mN_bte_i  in  2  master N burst type
- mN_dat_o  out  DW  read data to master N
- mN_ack_o / mN_err_o / mN_rty_o  out  1 each  termination to master N
- s_adr_o  out  AW ; s_dat_o  out  DW ; s_sel_o  out  DW/8  slave request
- s_we_o / s_cyc_o / s_stb_o  out  1 each ; s_cti_o  out  3 ; s_bte_o  out  2
- s_dat_i  in  DW ; s_ack_i / s_err_i / s_rty_i  in  1 each  slave response
- grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1, 00 = idle)
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values: state IDLE, last_owner = m1 (so m0 wins the first tie), watchdog = 0, grant_o = 00, timeout_o = 0. All slave controls (cyc, stb, we) and all master terminations are 0 during and after reset until the first grant.
- States IDLE, OWN0, OWN1. State and last_owner are registered. All muxing is combinational from state.
- IDLE:
  - Only m0_cyc_i high -> OWN0.
  - Only m1_cyc_i high -> OWN1.
  - Both high -> the master that is not last_owner.
  - Arbitration latency is 1 cycle: slave cyc is first asserted in the cycle after the request is seen.
- OWNx:
  - s_* outputs = mx_* inputs. s_dat_i goes to both mN_dat_o.
  - Slave ack/err/rty go to master x only; the other master's terminations are 0.
  - Grant holds while mx_cyc_i = 1, regardless of stb gaps or CTI.
- Release (mx_cyc_i = 0 while in OWNx):
  - Other master's cyc high -> go directly to its OWN state, no idle cycle. Otherwise -> IDLE.
  - last_owner <= x.
  - s_cyc_o is forced to 0 in the release cycle.
- A slave ACK arriving while mx_cyc_i = 0 is dropped, not forwarded.
- Watchdog:
  - Counts while s_stb_o & ~(s_ack_i | s_err_i | s_rty_i). Clears on any termination, on leaving OWNx, and on reset.
  - When the count reaches TIMEOUT-1 and still no termination:
    - mx_err_o = 1 for that cycle; s_cyc_o and s_stb_o are forced to 0 that cycle.
    - timeout_o = 1 for that cycle.
    - state <= IDLE; last_owner <= x.
  - A slave ack in the same cycle as expiry wins: normal ack, no error.
- TIMEOUT = 0: the counter is held at 0 and never fires.
- Reset asserted mid-transaction: the transaction is abandoned next edge, with no termination to the master. The master must restart its cycle.
- Simultaneous request and release of the same master in one cycle cannot occur (CYC is level). Back-to-back cycles by the same master with no contender go through one idle cycle.

Decomposition:
- Shared package wb_arb_pkg:
  - state encodings ST_IDLE/ST_OWN0/ST_OWN1
  - Wishbone CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111)
- One sub-module, wb_arb_watchdog (params TIMEOUT, TW):
  - inputs wb_clk, wb_rst, run, clear
  - output expire

Test Plan:
- Single m0 read at adr 0x0000_0100, slave acks 1 cycle later with 0xDEADBEEF -> s_cyc_o rises the cycle after m0_cyc_i, m0_dat_o = 0xDEADBEEF with m0_ack_o, m1_ack_o stays 0, grant_o = 01.
- m0 and m1 assert cyc in the same cycle after reset -> m0 granted first. On m0 release, m1 is granted the next cycle with no IDLE gap. The next tie goes to m0.
- m1 4-beat INCR burst (cti 010,010,010,111) while m0 requests throughout -> grant_o stays 10 for all 4 acks, then switches to 01.
- TIMEOUT=8, slave never acks an m1 write -> m1_err_o and timeout_o pulse exactly 8 cycles after the first s_stb_o, s_cyc_o = 0 that cycle, state returns to IDLE.
- TIMEOUT=8, slave acks on the 8th cycle -> m1_ack_o = 1, m1_err_o = 0, timeout_o = 0.
- wb_rst pulsed during an m0 access awaiting ack -> next cycle s_cyc_o = 0 and grant_o = 00. A late s_ack_i is not forwarded to m0, and the first tie after reset goes to m0.
